branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- ID-stage branch resolution controller, directly downstream of the register-operand equality comparator in the MIPS pipeline.
- Consumes the comparator's 1-bit equal flag plus branch-type and hazard information.
- Inserts stall cycles until the forwarded operands are valid, then decides taken/not-taken.
- Issues a registered one-cycle PC redirect and IF/ID flush, with the branch target.

Parameters:
ADDR_WIDTH, 32, width of PC and branch target
IMM_WIDTH, 32, width of sign-extended immediate input
STALL_CNT_W, 2, width of internal stall counter; must hold max stall value 2

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous active-high reset
i_branch_valid  input  1  ID holds a branch; held stable by pipeline while o_stall=1
i_branch_type  input  2  00 none, 01 BEQ, 10 BNE, 11 reserved (treated as none)
i_eq  input  1  operand-equal flag from comparator
i_pc_plus4  input  ADDR_WIDTH  PC+4 of branch instruction
i_imm_sext  input  IMM_WIDTH  sign-extended 16-bit offset
i_hz_ex_alu  input  1  a branch source register is written by ALU op in EX
i_hz_ex_load  input  1  a branch source register is written by load in EX
i_hz_mem_load  input  1  a branch source register is written by load in MEM
o_stall  output  1  freeze PC and IF/ID, bubble into ID/EX
o_pc_src  output  1  one-cycle pulse: select o_branch_target as next PC
o_flush_ifid  output  1  one-cycle pulse: squash IF/ID
o_branch_target  output  ADDR_WIDTH  registered target
o_busy  output  1  FSM not in IDLE

Behaviour:
- Reset, synchronous, i_rst=1 at clock edge: state=IDLE, counter=0, all outputs 0, o_branch_target=0. Reset has priority over all other inputs, including mid-stall.
- Active branch: i_branch_valid=1 and i_branch_type in {01,10}. Anything else is ignored in IDLE.
- Required stalls N, evaluated in IDLE only:
  - i_hz_ex_load gives N=2.
  - Otherwise i_hz_ex_alu or i_hz_mem_load gives N=1.
  - Otherwise N=0.
  - Priority is in that order when several hazards are set.
- States: IDLE, WAIT, REDIRECT.
- IDLE:
  - Active branch with N=0: evaluate now.
  - Active branch with N>0: counter<=N-1, go WAIT. o_stall=1 combinationally in this same cycle.
- WAIT:
  - o_stall=1 while counter>0 or on entry.
  - Each cycle counter decrements; hazard inputs are ignored.
  - When counter==0 at a clock edge, evaluate on that edge.
  - o_stall=0 in the cycle the evaluation edge closes.
  - If i_branch_valid drops in WAIT (external flush): return to IDLE, no redirect.
- Evaluate:
  - taken = (BEQ and i_eq) or (BNE and !i_eq).
  - Taken: next cycle o_pc_src=1, o_flush_ifid=1, o_branch_target=i_pc_plus4 + (i_imm_sext<<2), state=REDIRECT.
  - Not taken: state IDLE, no pulse.
- Target arithmetic: truncated to ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH. Shifted immediate bits above ADDR_WIDTH are discarded.
- REDIRECT:
  - Pulses last exactly one cycle, then IDLE.
  - A branch presented in the REDIRECT cycle is the squashed slot and is ignored.
- o_branch_target holds its last value outside REDIRECT.
- Latency: no hazard gives pulse 1 cycle after branch seen; hazard N gives pulse N+1 cycles after.
- o_busy=1 in WAIT and REDIRECT.

Optional Feature:
BRANCH_STATS_EN defined:
- Adds outputs o_taken_cnt, o_not_taken_cnt and o_stall_cycles, each 32 bits.
- Each counter increments once per event, saturates at 0xFFFFFFFF, and clears on reset.
- An aborted branch counts its stall cycles but neither outcome.

BRANCH_STATS_EN undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles mid-WAIT -> o_stall=0, o_pc_src=0, o_busy=0, o_branch_target=0 the cycle after reset.
- BEQ, i_eq=1, no hazards, pc_plus4=0x00400010, imm=0x00000004 -> next cycle o_pc_src=o_flush_ifid=1 for 1 cycle, target=0x00400020.
- BNE, i_eq=1, no hazards -> no pulse, o_stall stays 0, FSM stays IDLE.
- BEQ with i_hz_ex_load=1 and i_hz_ex_alu=1, i_eq=1 at eval, imm=0xFFFFFFFF -> o_stall high 2 cycles, pulse on 3rd cycle, target=pc_plus4-4.
- BEQ with i_hz_mem_load=1, i_branch_valid dropped during stall -> return IDLE, no pulse.
- pc_plus4=0xFFFFFFFC, imm=0x00000002, taken -> target=0x00000004 (wrap). With BRANCH_STATS_EN defined: o_taken_cnt increments 1.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution: stalls on operand hazards, then resolves BEQ/BNE and
// issues a registered one-cycle redirect/flush. Define BRANCH_STATS_EN to add event counters.
module branch_resolve_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int IMM_WIDTH   = 32,
    parameter int STALL_CNT_W = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_branch_valid,
    input  logic [1:0]            i_branch_type,
    input  logic                  i_eq,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    input  logic [IMM_WIDTH-1:0]  i_imm_sext,
    input  logic                  i_hz_ex_alu,
    input  logic                  i_hz_ex_load,
    input  logic                  i_hz_mem_load,
    output logic                  o_stall,
    output logic                  o_pc_src,
    output logic                  o_flush_ifid,
    output logic [ADDR_WIDTH-1:0] o_branch_target,
    output logic                  o_busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           o_taken_cnt,
    output logic [31:0]           o_not_taken_cnt,
    output logic [31:0]           o_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REDIRECT
    } state_t;

    localparam logic [1:0] TYPE_BEQ = 2'b01;
    localparam logic [1:0] TYPE_BNE = 2'b10;

    state_t                  state_reg, state_next;
    logic [STALL_CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0]   target_reg, target_next;
    logic [ADDR_WIDTH-1:0]   imm_addr;
    logic [ADDR_WIDTH-1:0]   branch_sum;
    logic [STALL_CNT_W-1:0]  need;
    logic                    active;
    logic                    taken;
    logic                    eval;
    logic                    stall_comb;
    logic                    unused_imm_hi;

    // Offset << 2 resized to the address width: sign-extend upward or drop the high bits.
    generate
        for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_imm
            if (gi < 2) begin : g_zero
                assign imm_addr[gi] = 1'b0;
            end else if (gi - 2 < IMM_WIDTH) begin : g_bit
                assign imm_addr[gi] = i_imm_sext[gi-2];
            end else begin : g_sign
                assign imm_addr[gi] = i_imm_sext[IMM_WIDTH-1];
            end
        end
        if (ADDR_WIDTH < IMM_WIDTH + 2) begin : g_drop
            assign unused_imm_hi = ^i_imm_sext[IMM_WIDTH-1:ADDR_WIDTH-2];
        end else begin : g_keep
            assign unused_imm_hi = 1'b0;
        end
    endgenerate

    assign branch_sum = i_pc_plus4 + imm_addr;
    assign active     = i_branch_valid && (i_branch_type == TYPE_BEQ || i_branch_type == TYPE_BNE);
    assign taken      = (i_branch_type == TYPE_BEQ && i_eq) || (i_branch_type == TYPE_BNE && !i_eq);

    always_comb begin
        need = '0;
        if (i_hz_ex_load) begin
            need = STALL_CNT_W'(2);
        end else if (i_hz_ex_alu || i_hz_mem_load) begin
            need = STALL_CNT_W'(1);
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        target_next = target_reg;
        stall_comb  = 1'b0;
        eval        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (active) begin
                    if (need == '0) begin
                        eval = 1'b1;
                    end else begin
                        cnt_next   = need - STALL_CNT_W'(1);
                        state_next = WAIT;
                        stall_comb = 1'b1;
                    end
                end
            end
            WAIT: begin
                stall_comb = (cnt_reg != '0);
                // A dropped valid means the branch was flushed from ID underneath us.
                if (!i_branch_valid) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    eval = 1'b1;
                end else begin
                    cnt_next = cnt_reg - STALL_CNT_W'(1);
                end
            end
            REDIRECT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        if (eval) begin
            cnt_next   = '0;
            state_next = IDLE;
            if (taken) begin
                target_next = branch_sum;
                state_next  = REDIRECT;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            target_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            target_reg <= target_next;
        end
    end

    // Redirect pulses come straight from the state register, so they are glitch-free.
    assign o_stall         = stall_comb && !i_rst;
    assign o_pc_src        = (state_reg == REDIRECT);
    assign o_flush_ifid    = (state_reg == REDIRECT);
    assign o_branch_target = target_reg;
    assign o_busy          = (state_reg != IDLE);

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt_reg, not_taken_cnt_reg, stall_cycles_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            taken_cnt_reg     <= '0;
            not_taken_cnt_reg <= '0;
            stall_cycles_reg  <= '0;
        end else begin
            if (eval && taken && taken_cnt_reg != 32'hFFFF_FFFF) begin
                taken_cnt_reg <= taken_cnt_reg + 32'd1;
            end
            if (eval && !taken && not_taken_cnt_reg != 32'hFFFF_FFFF) begin
                not_taken_cnt_reg <= not_taken_cnt_reg + 32'd1;
            end
            if (o_stall && stall_cycles_reg != 32'hFFFF_FFFF) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
        end
    end

    assign o_taken_cnt     = taken_cnt_reg;
    assign o_not_taken_cnt = not_taken_cnt_reg;
    assign o_stall_cycles  = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized bench for branch_resolve_ctrl: each branch is predicted as a whole
// (stall count, pulse cycle, target) and compared cycle by cycle.
module tb_branch_resolve_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_branch_valid;
    logic [1:0]  i_branch_type;
    logic        i_eq;
    logic [31:0] i_pc_plus4;
    logic [31:0] i_imm_sext;
    logic        i_hz_ex_alu;
    logic        i_hz_ex_load;
    logic        i_hz_mem_load;
    logic        o_stall;
    logic        o_pc_src;
    logic        o_flush_ifid;
    logic [31:0] o_branch_target;
    logic        o_busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_target = 32'h0;

    branch_resolve_ctrl #(
        .ADDR_WIDTH (32),
        .IMM_WIDTH  (32),
        .STALL_CNT_W(2)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_branch_valid (i_branch_valid),
        .i_branch_type  (i_branch_type),
        .i_eq           (i_eq),
        .i_pc_plus4     (i_pc_plus4),
        .i_imm_sext     (i_imm_sext),
        .i_hz_ex_alu    (i_hz_ex_alu),
        .i_hz_ex_load   (i_hz_ex_load),
        .i_hz_mem_load  (i_hz_mem_load),
        .o_stall        (o_stall),
        .o_pc_src       (o_pc_src),
        .o_flush_ifid   (o_flush_ifid),
        .o_branch_target(o_branch_target),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic clear_inputs();
        i_branch_valid = 1'b0;
        i_branch_type  = 2'b00;
        i_eq           = 1'b0;
        i_pc_plus4     = 32'h0;
        i_imm_sext     = 32'h0;
        i_hz_ex_alu    = 1'b0;
        i_hz_ex_load   = 1'b0;
        i_hz_mem_load  = 1'b0;
    endtask

    // Drives one branch through its whole life and checks every cycle against
    // the predicted timeline: stalls in cycles 0..n-1, pulse in cycle n+1.
    task automatic run_branch(input bit v, input logic [1:0] ty, input bit eq,
                              input bit exl, input bit exa, input bit meml,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input int abort_at);
        bit active, tk, ab, exp_stall, exp_pulse, exp_busy;
        int n, last;
        active = v && (ty == 2'b01 || ty == 2'b10);
        n      = !active ? 0 : (exl ? 2 : ((exa || meml) ? 1 : 0));
        tk     = active && ((ty == 2'b01 && eq) || (ty == 2'b10 && !eq));
        ab     = active && n > 0 && abort_at >= 1 && abort_at <= n;
        last   = ab ? abort_at + 1 : n + 1;
        for (int k = 0; k <= last; k++) begin
            @(negedge i_clk);
            if (ab && k >= abort_at) begin
                i_branch_valid = 1'b0;
            end else if (k <= n) begin
                i_branch_valid = v;   i_branch_type = ty;  i_eq = eq;
                i_hz_ex_load   = exl; i_hz_ex_alu   = exa; i_hz_mem_load = meml;
                i_pc_plus4     = pc;  i_imm_sext    = imm;
            end else if (tk) begin
                // Squashed delay slot: a live-looking branch that must be ignored.
                i_branch_valid = 1'b1;
                i_branch_type  = 2'($urandom_range(1, 2));
                i_eq           = 1'($urandom);
                i_hz_ex_load   = 1'($urandom);
                i_pc_plus4     = $urandom;
                i_imm_sext     = $urandom;
            end else begin
                i_branch_valid = 1'b0;
            end
            #1;
            exp_stall = active && k < n;
            exp_pulse = tk && !ab && k == n + 1;
            exp_busy  = ab ? (k >= 1 && k <= abort_at)
                           : ((active && k >= 1 && k <= n) || exp_pulse);
            if (exp_pulse) exp_target = pc + imm * 32'd4;
            if (!(ab && k == abort_at)) begin
                total++;
                if (o_stall !== exp_stall) begin
                    bad++;
                    $display("FAIL stall k=%0d got=%b want=%b", k, o_stall, exp_stall);
                end
            end
            total++;
            if (o_pc_src !== exp_pulse) begin
                bad++;
                $display("FAIL pc_src k=%0d got=%b want=%b", k, o_pc_src, exp_pulse);
            end
            total++;
            if (o_flush_ifid !== exp_pulse) begin
                bad++;
                $display("FAIL flush k=%0d got=%b want=%b", k, o_flush_ifid, exp_pulse);
            end
            total++;
            if (o_busy !== exp_busy) begin
                bad++;
                $display("FAIL busy k=%0d got=%b want=%b", k, o_busy, exp_busy);
            end
            total++;
            if (o_branch_target !== exp_target) begin
                bad++;
                $display("FAIL target k=%0d got=%h want=%h", k, o_branch_target, exp_target);
            end
        end
        $display("txn v=%0d ty=%0d eq=%0d n=%0d taken=%0d abort=%0d pc=%h imm=%h target=%h",
                 v, ty, eq, n, tk, ab, pc, imm, exp_target);
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        total++;
        if ({o_stall, o_pc_src, o_flush_ifid, o_busy} !== 4'b0000 || o_branch_target !== 32'h0) begin
            bad++;
            $display("FAIL reset_state got=%b%b%b%b tgt=%h want=0000 tgt=0",
                     o_stall, o_pc_src, o_flush_ifid, o_busy, o_branch_target);
        end
        exp_target = 32'h0;
    endtask

    task automatic test_directed();
        run_branch(1, 2'b01, 1, 0, 0, 0, 32'h0040_0010, 32'h0000_0004, -1);
        total++;
        if (o_branch_target !== 32'h0040_0020) begin
            bad++;
            $display("FAIL beq_target got=%h want=00400020", o_branch_target);
        end
        run_branch(1, 2'b10, 1, 0, 0, 0, 32'h0000_1000, 32'h0000_0010, -1);
        run_branch(1, 2'b01, 1, 1, 1, 0, 32'h0000_2000, 32'hFFFF_FFFF, -1);
        total++;
        if (o_branch_target !== 32'h0000_1FFC) begin
            bad++;
            $display("FAIL back_target got=%h want=00001ffc", o_branch_target);
        end
        run_branch(1, 2'b01, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0002, -1);
        total++;
        if (o_branch_target !== 32'h0000_0004) begin
            bad++;
            $display("FAIL wrap_target got=%h want=00000004", o_branch_target);
        end
        run_branch(1, 2'b11, 1, 1, 0, 0, 32'h0000_3000, 32'h0000_0001, -1);
        run_branch(0, 2'b01, 1, 1, 0, 0, 32'h0000_3000, 32'h0000_0001, -1);
    endtask

    task automatic test_abort();
        run_branch(1, 2'b01, 1, 0, 0, 1, 32'h0000_4000, 32'h0000_0008, 1);
        run_branch(1, 2'b10, 0, 1, 0, 0, 32'h0000_5000, 32'h0000_0008, 2);
        run_branch(1, 2'b10, 0, 1, 0, 0, 32'h0000_6000, 32'h0000_0008, 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 150; t++) begin
            bit v, exl, exa, meml;
            int n, ab_at;
            v    = ($urandom_range(0, 9) != 0);
            exl  = ($urandom_range(0, 3) == 0);
            exa  = 1'($urandom);
            meml = 1'($urandom);
            n    = exl ? 2 : ((exa || meml) ? 1 : 0);
            ab_at = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : -1;
            run_branch(v, 2'($urandom), 1'($urandom), exl, exa, meml,
                       $urandom, $urandom, ab_at);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge i_clk);
        clear_inputs();
        i_branch_valid = 1'b1; i_branch_type = 2'b01; i_eq = 1'b1;
        i_hz_ex_load   = 1'b1; i_pc_plus4 = 32'h0000_7000; i_imm_sext = 32'h4;
        @(negedge i_clk);
        #1;
        total++;
        if (o_busy !== 1'b1 || o_stall !== 1'b1) begin
            bad++;
            $display("FAIL wait_entry busy=%b stall=%b want=1 1", o_busy, o_stall);
        end
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        clear_inputs();
        #1;
        total++;
        if ({o_stall, o_pc_src, o_flush_ifid, o_busy} !== 4'b0000 || o_branch_target !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_wait got=%b%b%b%b tgt=%h want=0000 tgt=0",
                     o_stall, o_pc_src, o_flush_ifid, o_busy, o_branch_target);
        end
        exp_target = 32'h0;
        run_branch(1, 2'b10, 0, 0, 1, 0, 32'h0000_8000, 32'h0000_0003, -1);
    endtask

    initial begin
        clear_inputs();
        i_rst = 1'b1;
        test_reset();
        test_directed();
        test_abort();
        test_random();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
